// File: rtl/buffer_reader_if.sv
// Bus bundle between a burst-read controller and the buffer_reader block.
//
// Handshake: a word moves downstream in every cycle where out_valid=1 and
// out_ready=1 are both high at the rising clock edge. While out_valid=1 and
// out_ready=0 the producer keeps out_data unchanged; out_valid never drops
// without an accepting edge. start is a single-cycle request that is only
// honoured while the reader is idle. rd_q is the buffer's combinational
// read data for address ra.
interface buffer_reader_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int WORD_WIDTH = 8
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] base;
   logic [ADDR_WIDTH:0]   len;
   logic [ADDR_WIDTH-1:0] ra;
   logic [WORD_WIDTH-1:0] rd_q;
   logic [WORD_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  busy;
   logic                  done;

   // Controller / environment side.
   modport master (
      output start, base, len, rd_q, out_ready,
      input  ra, out_data, out_valid, busy, done
   );

   // Reader side.
   modport slave (
      input  start, base, len, rd_q, out_ready,
      output ra, out_data, out_valid, busy, done
   );
endinterface

// File: rtl/buffer_reader.sv
// Burst reader: walks len consecutive buffer addresses starting at base,
// wrapping at WORD_NUM, and streams each word out over a valid/ready port.
// The read address is registered; the buffer returns data combinationally,
// so a word is captured one cycle after its address is presented.
module buffer_reader #(
   parameter int ADDR_WIDTH = 8,
   parameter int WORD_NUM   = 196,
   parameter int WORD_WIDTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   buffer_reader_if.slave      bus,
   output logic [1:0]          dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_e;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_NUM - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   MAX_LEN   = (ADDR_WIDTH + 1)'(WORD_NUM);
   localparam logic [ADDR_WIDTH:0]   LEN_ONE   = (ADDR_WIDTH + 1)'(1);

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] ra_q;
   logic [ADDR_WIDTH:0]   remaining_q;
   logic [WORD_WIDTH-1:0] out_data_q;
   logic                  out_valid_q;
   logic                  busy_q;
   logic                  done_q;
   logic [ADDR_WIDTH-1:0] ra_d;

   // Next read address: wraps at the buffer depth, not at the address width.
   always_comb begin
      ra_d = (ra_q == LAST_ADDR) ? '0 : ra_q + ADDR_ONE;
   end

   // Control FSM with all outputs registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         ra_q        <= '0;
         remaining_q <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  if (bus.len != '0) begin
                     ra_q        <= bus.base;
                     remaining_q <= bus.len;
                     busy_q      <= 1'b1;
                     state_q     <= STREAM;
                  end else begin
                     // Empty burst: report completion without streaming.
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            STREAM: begin
               if (out_valid_q && bus.out_ready && (remaining_q == '0)) begin
                  // Final word accepted.
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= DONE;
               end else if ((remaining_q != '0) && (!out_valid_q || bus.out_ready)) begin
                  // Load slot: output register is free or being drained now.
                  out_data_q  <= bus.rd_q;
                  out_valid_q <= 1'b1;
                  remaining_q <= remaining_q - LEN_ONE;
                  ra_q        <= ra_d;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Range check on accepted burst requests; the datapath does not act on it.
   always_ff @(posedge clk) begin
      if (reset && (state_q == IDLE) && bus.start) begin
         assert ((bus.base <= LAST_ADDR) && (bus.len <= MAX_LEN));
      end
   end

   assign bus.ra        = ra_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_buffer_reader.sv
// Bench for buffer_reader: directed latency/wrap/backpressure/reset steps
// followed by randomized bursts, checked against a word-list model of the
// buffer contents.
module tb_buffer_reader;

   localparam int AW = 8;
   localparam int WN = 196;
   localparam int WW = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   buffer_reader_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus();
   logic [1:0] dbg_state;

   buffer_reader #(.ADDR_WIDTH(AW), .WORD_NUM(WN), .WORD_WIDTH(WW)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .dbg_state_o(dbg_state)
   );

   // Buffer model: combinational read of a preloaded array.
   logic [WW-1:0] mem [0:255];
   assign bus.rd_q = mem[bus.ra];

   // ---------------- scoreboard ----------------
   logic [WW-1:0] exp_q [$];
   int n_cmp  = 0;
   int n_fail = 0;
   int acc_cnt  = 0;
   int done_cnt = 0;
   int a_base = 0;
   int d_base = 0;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected word stream for a burst: consecutive addresses modulo depth.
   task automatic push_burst(input int b, input int l);
      for (int k = 0; k < l; k++) exp_q.push_back(mem[(b + k) % WN]);
   endtask

   // Monitor: accepted words, held data under stall, one-cycle done.
   logic          prev_stall = 1'b0;
   logic          prev_done  = 1'b0;
   logic [WW-1:0] prev_data  = '0;
   always @(negedge clk) begin
      if (!reset) begin
         prev_stall = 1'b0;
         prev_done  = 1'b0;
      end else begin
         if (prev_stall) begin
            cmp("hold_valid", bus.out_valid, 1);
            cmp("hold_data", bus.out_data, prev_data);
         end
         if (bus.out_valid && bus.out_ready) begin
            acc_cnt++;
            cmp("word_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) cmp("word_data", bus.out_data, exp_q.pop_front());
         end
         if (bus.done) begin
            done_cnt++;
            cmp("done_one_cycle", prev_done, 0);
         end
         prev_done  = bus.done;
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a start; returns one cycle after the accepting edge (cycle 1).
   task automatic start_burst(input int b, input int l);
      a_base    = acc_cnt;
      d_base    = done_cnt;
      bus.start = 1'b1;
      bus.base  = AW'(b);
      bus.len   = (AW + 1)'(l);
      push_burst(b, l);
      tick();
      bus.start = 1'b0;
   endtask

   // Run until done, optionally randomizing out_ready and injecting starts
   // that must be ignored; then check completion bookkeeping.
   task automatic run_to_done(input int l, input bit rnd_ready, input bit stray);
      int c;
      c = 0;
      while (!bus.done && c < 8 * l + 40) begin
         if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
         if (stray) begin
            bus.start = ($urandom_range(0, 1) == 1);
            bus.base  = AW'($urandom_range(0, WN - 1));
            bus.len   = (AW + 1)'($urandom_range(1, WN));
         end
         tick();
         c++;
      end
      bus.start = 1'b0;
      cmp("done_seen", bus.done, 1);
      cmp("done_busy_low", bus.busy, 0);
      cmp("done_valid_low", bus.out_valid, 0);
      cmp("drain", exp_q.size(), 0);
      exp_q.delete();
      tick();
      cmp("done_pulse_end", bus.done, 0);
      cmp("word_count", acc_cnt - a_base, l);
      cmp("done_count", done_cnt - d_base, 1);
      bus.out_ready = 1'b1;
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation time limit");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [15:0] pat;
      int b, l;
      reset         = 1'b0;
      bus.start     = 1'b0;
      bus.base      = '0;
      bus.len       = '0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = WW'(i);
      #2;
      cmp("rst_ra", bus.ra, 0);
      cmp("rst_data", bus.out_data, 0);
      cmp("rst_valid", bus.out_valid, 0);
      cmp("rst_busy", bus.busy, 0);
      cmp("rst_done", bus.done, 0);
      tick();
      tick();
      reset = 1'b1;

      // Basic burst: base=10, len=4, out_ready held.
      start_burst(10, 4);
      cmp("lat_ra", bus.ra, 10);
      cmp("lat_busy", bus.busy, 1);
      cmp("lat_valid", bus.out_valid, 0);
      for (int c = 2; c <= 5; c++) begin
         tick();
         cmp("basic_valid", bus.out_valid, 1);
         cmp("basic_data", bus.out_data, mem[10 + c - 2]);
         cmp("basic_busy", bus.busy, 1);
      end
      run_to_done(4, 1'b0, 1'b0);

      // Address wrap at the buffer depth.
      start_burst(194, 4);
      cmp("wrap_ra", bus.ra, 194);
      for (int c = 2; c <= 5; c++) begin
         tick();
         cmp("wrap_ra", bus.ra, (194 + c - 1) % WN);
         cmp("wrap_data", bus.out_data, mem[(194 + c - 2) % WN]);
      end
      run_to_done(4, 1'b0, 1'b0);

      // Backpressure: ready pattern 1,0,0,1,1,... from cycle 1.
      pat = 16'hFFF9;
      start_burst(10, 3);
      for (int i = 0; i < 16 && !bus.done; i++) begin
         bus.out_ready = pat[i];
         tick();
      end
      run_to_done(3, 1'b0, 1'b0);

      // Empty burst.
      start_burst(5, 0);
      cmp("len0_busy", bus.busy, 0);
      cmp("len0_valid", bus.out_valid, 0);
      cmp("len0_done", bus.done, 1);
      run_to_done(0, 1'b0, 1'b0);

      // Start re-asserted while streaming must be ignored.
      start_burst(20, 5);
      run_to_done(5, 1'b0, 1'b1);

      // Reset mid-burst after two words.
      start_burst(30, 6);
      tick();
      tick();
      tick();
      cmp("pre_rst_words", acc_cnt - a_base, 2);
      reset = 1'b0;
      #1;
      cmp("mid_rst_ra", bus.ra, 0);
      cmp("mid_rst_data", bus.out_data, 0);
      cmp("mid_rst_valid", bus.out_valid, 0);
      cmp("mid_rst_busy", bus.busy, 0);
      cmp("mid_rst_done", bus.done, 0);
      exp_q.delete();
      tick();
      tick();
      cmp("no_done_after_rst", done_cnt - d_base, 0);
      for (int i = 0; i < 256; i++) mem[i] = WW'($urandom);
      mem[0] = 8'hA5;
      reset = 1'b1;
      start_burst(0, 1);
      cmp("post_rst_busy", bus.busy, 1);
      cmp("post_rst_ra", bus.ra, 0);
      tick();
      cmp("post_rst_valid", bus.out_valid, 1);
      cmp("post_rst_data", bus.out_data, 8'hA5);
      run_to_done(1, 1'b0, 1'b0);

      // Randomized bursts with random backpressure and stray starts.
      for (int n = 0; n < 30; n++) begin
         b = $urandom_range(0, WN - 1);
         if (n == 7) l = WN;
         else if ($urandom_range(0, 7) == 0) l = 0;
         else l = $urandom_range(1, 24);
         start_burst(b, l);
         run_to_done(l, 1'b1, ($urandom_range(0, 1) == 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
